pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB).
//  Resolves load-use hazards, EX-stage taken branches and multi-cycle data-memory accesses.
//  Drives per-stage register-hold and bubble controls.
//  Sits beside the pipeline registers; all hazard decisions go through this block.
// PARAMETERS
//  REG_AW       5   register-index width
//  MEM_TIMEOUT  64  max dmem wait cycles before error (>=2)
//  CNT_W        32  perf counter width (PIPE_PERF_CNT_EN only)
// PORTS
//  i_clk               in   1      clock, rising edge
//  i_rst               in   1      synchronous reset, active-high
//  i_idex_mem_read     in   1      instr in EX is a load
//  i_idex_rd           in   REG_AW dest reg of instr in EX
//  i_ifid_rs1          in   REG_AW src1 of instr in ID
//  i_ifid_rs2          in   REG_AW src2 of instr in ID
//  i_ex_branch_taken   in   1      EX resolved branch/jump taken
//  i_exmem_mem_access  in   1      instr in MEM performs load/store
//  i_dmem_ready        in   1      dmem completes access this cycle
//  o_pc_write          out  1      PC update enable
//  o_stall_ifid        out  1      hold IF/ID register
//  o_stall_idex        out  1      hold ID/EX register
//  o_stall_exmem       out  1      hold EX/MEM register
//  o_flush_ifid        out  1      load bubble into IF/ID
//  o_flush_idex        out  1      load bubble into ID/EX
//  o_flush_memwb       out  1      load bubble into MEM/WB
//  o_mem_timeout       out  1      sticky error: dmem never ready
// BEHAVIOUR
//  - FSM states: RUN, MEM_WAIT, HALT. State, wait counter and error flag are registered.
//  - Outputs are combinational from state + inputs, valid in the same cycle.
//  - Reset (i_rst=1 at posedge): state<=RUN, wait_cnt<=0, o_mem_timeout<=0.
//    While i_rst=1: all o_flush_*=1, all o_stall_*=0, o_pc_write=0.
//  - Reset mid-MEM_WAIT or in HALT returns to RUN on the next cycle.
//  - Idle (no hazard): o_pc_write=1, all stall/flush=0.
//  - Priority, highest first: HALT > dmem wait > branch > load-use.
//  - dmem wait: condition i_exmem_mem_access & ~i_dmem_ready, in RUN or MEM_WAIT.
//    Outputs: o_pc_write=0, o_stall_ifid=o_stall_idex=o_stall_exmem=1, o_flush_memwb=1.
//    Branch and load-use outputs are suppressed (EX is frozen; re-evaluated after).
//    Next state MEM_WAIT; wait_cnt increments each wait cycle.
//  - MEM_WAIT exit: i_dmem_ready=1 gives no stall that cycle; state<=RUN, wait_cnt<=0.
//  - Timeout: wait cycle with wait_cnt==MEM_TIMEOUT-1 -> state<=HALT, o_mem_timeout<=1.
//    A ready in that same cycle wins: no timeout.
//  - HALT: o_pc_write=0, all stalls=1, o_flush_memwb=1. Exit only by reset.
//  - Branch (i_ex_branch_taken): o_flush_ifid=1, o_flush_idex=1, o_pc_write=1. Load-use ignored.
//  - Load-use: i_idex_mem_read & i_idex_rd!=0 & (rd==rs1 | rd==rs2).
//    Outputs: o_pc_write=0, o_stall_ifid=1, o_flush_idex=1. Exactly one bubble.
//    Next cycle the load is in MEM, so the hazard clears by construction.
//  - o_stall_X and o_flush_X are never both 1 for the same register.
// CONFIGURATION
//  PIPE_PERF_CNT_EN defined: adds o_cnt_load_use, o_cnt_branch, o_cnt_mem_wait (CNT_W each).
//    Each counts cycles where that cause is the winning priority.
//    Counters reset to 0, saturate at all-ones.
//  PIPE_PERF_CNT_EN undefined: ports and counters are absent; function is unchanged.
// STRUCTURE
//  Shared package pipe_ctrl_pkg: state enum (RUN/MEM_WAIT/HALT), hazard-cause enum (NONE/LOAD_USE/BRANCH/MEM_WAIT/HALT).
//  Sub-module load_use_detect: combinational rd/rs compare, reused by forwarding logic later.
// TESTING
//  1. Load x5; next instr uses rs1=x5 -> one cycle: pc_write=0, stall_ifid=1, flush_idex=1; then idle.
//  2. Load x0; dependent rs2=x0 -> no stall.
//  3. Branch taken and load-use in same cycle -> flush_ifid=flush_idex=1, pc_write=1, no stall.
//  4. mem_access=1, ready low 3 cycles then high -> 3 cycles all stalls + flush_memwb; RUN on 4th.
//  5. MEM_TIMEOUT=4, ready never high -> 4 wait cycles; o_mem_timeout=1 and HALT thereafter; i_rst -> RUN, flag 0.
//  6. i_rst during MEM_WAIT -> next cycle RUN, wait_cnt=0, all flush=1 while reset held.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard sequencer: FSM state codes and hazard-cause enum.
package pipe_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_RUN      = 2'd0;
  localparam state_t ST_MEM_WAIT = 2'd1;
  localparam state_t ST_HALT     = 2'd2;

  typedef enum logic [2:0] {
    CAUSE_NONE     = 3'd0,
    CAUSE_LOAD_USE = 3'd1,
    CAUSE_BRANCH   = 3'd2,
    CAUSE_MEM_WAIT = 3'd3,
    CAUSE_HALT     = 3'd4
  } cause_e;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use compare: load in EX writes a register read by the instruction in ID.
module load_use_detect #(
  parameter int unsigned REG_AW = 5
) (
  input  logic              mem_read_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic [REG_AW-1:0] rs1_i,
  input  logic [REG_AW-1:0] rs2_i,
  output logic              hazard_c_o
);

  // x0 is hardwired zero, so a load targeting it never creates a dependency
  always_comb begin
    hazard_c_o = mem_read_i && (rd_i != '0) && ((rd_i == rs1_i) || (rd_i == rs2_i));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: dmem wait, branch flush, load-use bubble.
// Optional perf counters are enabled by defining PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned MEM_TIMEOUT = 64
`ifdef PIPE_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W       = 32
`endif
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_idex_mem_read,
  input  logic [REG_AW-1:0] i_idex_rd,
  input  logic [REG_AW-1:0] i_ifid_rs1,
  input  logic [REG_AW-1:0] i_ifid_rs2,
  input  logic              i_ex_branch_taken,
  input  logic              i_exmem_mem_access,
  input  logic              i_dmem_ready,
  output logic              o_pc_write,
  output logic              o_stall_ifid,
  output logic              o_stall_idex,
  output logic              o_stall_exmem,
  output logic              o_flush_ifid,
  output logic              o_flush_idex,
  output logic              o_flush_memwb,
  output logic              o_mem_timeout
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  o_cnt_load_use,
  output logic [CNT_W-1:0]  o_cnt_branch,
  output logic [CNT_W-1:0]  o_cnt_mem_wait
`endif
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;
  logic              load_use_c;
  logic              mem_wait_c;
  cause_e            cause_c;

  load_use_detect #(.REG_AW(REG_AW)) u_load_use_detect (
    .mem_read_i (i_idex_mem_read),
    .rd_i       (i_idex_rd),
    .rs1_i      (i_ifid_rs1),
    .rs2_i      (i_ifid_rs2),
    .hazard_c_o (load_use_c)
  );

  assign mem_wait_c = i_exmem_mem_access && !i_dmem_ready;

  // Winning hazard cause, highest priority first
  always_comb begin
    cause_c = CAUSE_NONE;
    if (state_q == ST_HALT)  cause_c = CAUSE_HALT;
    else if (mem_wait_c)     cause_c = CAUSE_MEM_WAIT;
    else if (i_ex_branch_taken) cause_c = CAUSE_BRANCH;
    else if (load_use_c)     cause_c = CAUSE_LOAD_USE;
  end

  // Next-state logic; a ready on the last allowed wait cycle avoids the timeout
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    if (state_q != ST_HALT) begin
      if (mem_wait_c) begin
        if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
          state_d   = ST_HALT;
          timeout_d = 1'b1;
        end else begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end else begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // Per-stage controls decoded from the winning cause; reset forces bubbles everywhere
  always_comb begin
    o_pc_write    = 1'b1;
    o_stall_ifid  = 1'b0;
    o_stall_idex  = 1'b0;
    o_stall_exmem = 1'b0;
    o_flush_ifid  = 1'b0;
    o_flush_idex  = 1'b0;
    o_flush_memwb = 1'b0;
    if (i_rst) begin
      o_pc_write    = 1'b0;
      o_flush_ifid  = 1'b1;
      o_flush_idex  = 1'b1;
      o_flush_memwb = 1'b1;
    end else begin
      case (cause_c)
        CAUSE_HALT, CAUSE_MEM_WAIT: begin
          o_pc_write    = 1'b0;
          o_stall_ifid  = 1'b1;
          o_stall_idex  = 1'b1;
          o_stall_exmem = 1'b1;
          o_flush_memwb = 1'b1;
        end
        CAUSE_BRANCH: begin
          o_flush_ifid = 1'b1;
          o_flush_idex = 1'b1;
        end
        CAUSE_LOAD_USE: begin
          o_pc_write   = 1'b0;
          o_stall_ifid = 1'b1;
          o_flush_idex = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_mem_timeout = timeout_q;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_load_use_q, cnt_branch_q, cnt_mem_wait_q;

  // Saturating event counters, one per winning cause
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_load_use_q <= '0;
      cnt_branch_q   <= '0;
      cnt_mem_wait_q <= '0;
    end else begin
      if (cause_c == CAUSE_LOAD_USE && cnt_load_use_q != '1)
        cnt_load_use_q <= cnt_load_use_q + CNT_W'(1);
      if (cause_c == CAUSE_BRANCH && cnt_branch_q != '1)
        cnt_branch_q <= cnt_branch_q + CNT_W'(1);
      if (cause_c == CAUSE_MEM_WAIT && cnt_mem_wait_q != '1)
        cnt_mem_wait_q <= cnt_mem_wait_q + CNT_W'(1);
    end
  end

  assign o_cnt_load_use = cnt_load_use_q;
  assign o_cnt_branch   = cnt_branch_q;
  assign o_cnt_mem_wait = cnt_mem_wait_q;
`else
  // Perf counters absent: control behaviour is identical
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl with a short dmem timeout.
module tb_pipe_hazard_ctrl;

  localparam int unsigned REG_AW      = 5;
  localparam int unsigned MEM_TIMEOUT = 4;

  // {pc_write, stall_ifid, stall_idex, stall_exmem, flush_ifid, flush_idex, flush_memwb, mem_timeout}
  localparam logic [7:0] E_IDLE   = 8'b1000_0000;
  localparam logic [7:0] E_RST    = 8'b0000_1110;
  localparam logic [7:0] E_RST_TO = 8'b0000_1111;
  localparam logic [7:0] E_LU     = 8'b0100_0100;
  localparam logic [7:0] E_BR     = 8'b1000_1100;
  localparam logic [7:0] E_MW     = 8'b0111_0010;
  localparam logic [7:0] E_HALT   = 8'b0111_0011;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              idex_mem_read = 1'b0;
  logic [REG_AW-1:0] idex_rd = '0;
  logic [REG_AW-1:0] ifid_rs1 = '0;
  logic [REG_AW-1:0] ifid_rs2 = '0;
  logic              ex_branch_taken = 1'b0;
  logic              exmem_mem_access = 1'b0;
  logic              dmem_ready = 1'b0;
  logic pc_write, stall_ifid, stall_idex, stall_exmem;
  logic flush_ifid, flush_idex, flush_memwb, mem_timeout;
  logic [7:0] obs;

  logic [7:0] exp_q[$];
  string      tag_q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_AW(REG_AW), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_idex_mem_read    (idex_mem_read),
    .i_idex_rd          (idex_rd),
    .i_ifid_rs1         (ifid_rs1),
    .i_ifid_rs2         (ifid_rs2),
    .i_ex_branch_taken  (ex_branch_taken),
    .i_exmem_mem_access (exmem_mem_access),
    .i_dmem_ready       (dmem_ready),
    .o_pc_write         (pc_write),
    .o_stall_ifid       (stall_ifid),
    .o_stall_idex       (stall_idex),
    .o_stall_exmem      (stall_exmem),
    .o_flush_ifid       (flush_ifid),
    .o_flush_idex       (flush_idex),
    .o_flush_memwb      (flush_memwb),
    .o_mem_timeout      (mem_timeout)
  );

  assign obs = {pc_write, stall_ifid, stall_idex, stall_exmem,
                flush_ifid, flush_idex, flush_memwb, mem_timeout};

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs after the falling edge, then compare mid-low-phase
  task automatic drive(input string tag, input logic r, input logic ld,
                       input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] rs1,
                       input logic [REG_AW-1:0] rs2, input logic br, input logic acc,
                       input logic rdy, input logic [7:0] exp);
    @(negedge clk);
    rst              = r;
    idex_mem_read    = ld;
    idex_rd          = rd;
    ifid_rs1         = rs1;
    ifid_rs2         = rs2;
    ex_branch_taken  = br;
    exmem_mem_access = acc;
    dmem_ready       = rdy;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    #2;
    check_eq(tag_q.pop_front(), obs, exp_q.pop_front());
  endtask

  task automatic idle(input string tag, input logic [7:0] exp);
    drive(tag, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, exp);
  endtask

  task automatic mem_cycle(input string tag, input logic rdy, input logic [7:0] exp);
    drive(tag, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, rdy, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    drive("reset", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, E_RST);
    idle("idle", E_IDLE);

    // load-use on rs1, then on rs2, then the bubble has gone
    drive("lu_rs1", 1'b0, 1'b1, 5'd5, 5'd5, 5'd7, 1'b0, 1'b0, 1'b0, E_LU);
    idle("lu_after", E_IDLE);
    drive("lu_rs2", 1'b0, 1'b1, 5'd9, 5'd3, 5'd9, 1'b0, 1'b0, 1'b0, E_LU);
    drive("load_x0", 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, E_IDLE);
    drive("nonload_match", 1'b0, 1'b0, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, E_IDLE);
    drive("load_nomatch", 1'b0, 1'b1, 5'd4, 5'd5, 5'd6, 1'b0, 1'b0, 1'b0, E_IDLE);

    // branch beats load-use
    drive("br_over_lu", 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, E_BR);
    drive("br_only", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, E_BR);

    // 3-cycle dmem wait, branch suppressed inside it, exit on ready
    mem_cycle("mw1", 1'b0, E_MW);
    drive("mw2_br", 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, E_MW);
    mem_cycle("mw3", 1'b0, E_MW);
    mem_cycle("mw_ready", 1'b1, E_IDLE);
    idle("mw_after", E_IDLE);

    // ready on the last allowed wait cycle: no timeout
    mem_cycle("edge_w1", 1'b0, E_MW);
    mem_cycle("edge_w2", 1'b0, E_MW);
    mem_cycle("edge_w3", 1'b0, E_MW);
    mem_cycle("edge_ready", 1'b1, E_IDLE);
    idle("edge_after", E_IDLE);

    // timeout after MEM_TIMEOUT wait cycles, HALT until reset
    mem_cycle("to_w1", 1'b0, E_MW);
    mem_cycle("to_w2", 1'b0, E_MW);
    mem_cycle("to_w3", 1'b0, E_MW);
    mem_cycle("to_w4", 1'b0, E_MW);
    idle("halt1", E_HALT);
    mem_cycle("halt_ready", 1'b1, E_HALT);
    drive("halt_br", 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, E_HALT);
    drive("halt_rst1", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, E_RST_TO);
    drive("halt_rst2", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, E_RST);
    idle("halt_exit", E_IDLE);

    // reset in MEM_WAIT clears the wait counter
    mem_cycle("rw_w1", 1'b0, E_MW);
    mem_cycle("rw_w2", 1'b0, E_MW);
    drive("rw_rst", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, E_RST);
    mem_cycle("rw_w1b", 1'b0, E_MW);
    mem_cycle("rw_w2b", 1'b0, E_MW);
    mem_cycle("rw_w3b", 1'b0, E_MW);
    mem_cycle("rw_ready", 1'b1, E_IDLE);
    idle("rw_after", E_IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
